// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic             Start_in,
  input  logic [5:0]       Funct_in,
  input  logic             Flush_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             Busy_out,
  output logic             Done_out,
  output logic             DivZero_out,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag;
  logic [WIDTH-1:0]   a_raw;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic               done;
  logic               divz;

  logic op_md, op_sgn, op_div, op_mthi, op_mtlo;

  always_comb begin
    op_md   = 1'b0;
    op_sgn  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (Funct_in)
      F_MULT: begin
        op_md  = 1'b1;
        op_sgn = 1'b1;
      end
      F_MULTU: op_md = 1'b1;
      F_DIV: begin
        op_md  = 1'b1;
        op_sgn = 1'b1;
        op_div = 1'b1;
      end
      F_DIVU: begin
        op_md  = 1'b1;
        op_div = 1'b1;
      end
      F_MTHI: op_mthi = 1'b1;
      F_MTLO: op_mtlo = 1'b1;
      default: ;
    endcase
  end

  logic accept, start_md, start_mt, last, commit;

  assign accept   = (state == IDLE) && Start_in && !Flush_in;
  assign start_md = accept && op_md;
  assign start_mt = accept && (op_mthi || op_mtlo);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign commit   = (state == FIX) && !Flush_in;

  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_abs = (op_sgn && A_in[WIDTH-1]) ? -A_in : A_in;
  assign b_abs = (op_sgn && B_in[WIDTH-1]) ? -B_in : B_in;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_md) state_nx = RUN;
      RUN: begin
        if (Flush_in) state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or posedge Rst_in) begin
    if (Rst_in) state <= IDLE;
    else state <= state_nx;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_try;
  logic               div_ok;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, mag} : '0);
    div_try = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag};
    div_ok  = !div_try[WIDTH];
    if (is_div)
      acc_step = {div_ok ? div_try[WIDTH-1:0]
                         : acc[2*WIDTH-2:WIDTH-1],
                  acc[WIDTH-2:0], div_ok};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                   : acc[2*WIDTH-1:WIDTH];
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (is_div) begin
      hi_fix = div_zero ? a_raw : rem;
      lo_fix = div_zero ? '1 : quo;
    end
  end

  always_ff @(posedge Clk_in or posedge Rst_in) begin
    if (Rst_in) begin
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      mag      <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      divz     <= 1'b0;
    end else begin
      done <= 1'b0;
      divz <= 1'b0;
      if (start_md) begin
        acc      <= {{WIDTH{1'b0}}, op_div ? a_abs : b_abs};
        mag      <= op_div ? b_abs : a_abs;
        is_div   <= op_div;
        neg_res  <= op_sgn && (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
        neg_rem  <= op_sgn && A_in[WIDTH-1];
        div_zero <= op_div && (B_in == '0);
        a_raw    <= A_in;
        cnt      <= '0;
      end
      if (start_mt) begin
        if (op_mthi) hi <= A_in;
        else lo <= A_in;
        done <= 1'b1;
      end
      if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (commit) begin
        hi   <= hi_fix;
        lo   <= lo_fix;
        done <= 1'b1;
        divz <= is_div && div_zero;
      end
    end
  end

  assign Busy_out    = (state != IDLE);
  assign Done_out    = done;
  assign DivZero_out = divz;
  assign Hi_out      = hi;
  assign Lo_out      = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic         flush = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, divz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk_in     (clk),
    .Rst_in     (rst),
    .Start_in   (start),
    .Funct_in   (funct),
    .Flush_in   (flush),
    .A_in       (a_in),
    .B_in       (b_in),
    .Busy_out   (busy),
    .Done_out   (done),
    .DivZero_out(divz),
    .Hi_out     (hi),
    .Lo_out     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [5:0] f,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] h,
                                output logic [W-1:0] l,
                                output logic dz);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    h = m_hi;
    l = m_lo;
    dz = 1'b0;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = sp;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
      end
      F_DIV: begin
        if (b == 0) begin
          h = a; l = '1; dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == '1) begin
          h = '0; l = a;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      F_DIVU: begin
        if (b == 0) begin
          h = a; l = '1; dz = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      F_MTHI: h = a;
      F_MTLO: l = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] f,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int inj,
                        input int fl);
    logic [W-1:0] eh, el;
    logic edz;
    bit fin;
    bit flushed;
    model(f, a, b, eh, el, edz);
    @(negedge clk);
    start = 1'b1; funct = f; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom;
    if (f == F_MTHI || f == F_MTLO) begin
      chk("mt_done", 64'(done), 64'd1);
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_hi", 64'(hi), 64'(eh));
      chk("mt_lo", 64'(lo), 64'(el));
      m_hi = eh; m_lo = el;
      return;
    end
    chk("acc_busy", 64'(busy), 64'd1);
    fin = 0;
    flushed = 0;
    for (int k = 1; k <= W + 10; k++) begin
      start = (k == inj);
      funct = (k == inj) ? F_DIVU : f;
      flush = (k == fl);
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      if (k == fl) begin
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_done", 64'(done), 64'd0);
        flushed = 1;
        break;
      end
      if (done) begin
        chk("latency", 64'(k), 64'(W + 1));
        chk("end_busy", 64'(busy), 64'd0);
        chk("res_hi", 64'(hi), 64'(eh));
        chk("res_lo", 64'(lo), 64'(el));
        chk("res_dz", 64'(divz), 64'(edz));
        fin = 1;
        break;
      end
      if (!busy) chk("run_busy", 64'(busy), 64'd1);
    end
    if (flushed) begin
      for (int k = 0; k < W + 4; k++) begin
        @(posedge clk); #1;
        if (done) chk("fl_nodone", 64'(done), 64'd0);
      end
      chk("fl_hi", 64'(hi), 64'(m_hi));
      chk("fl_lo", 64'(lo), 64'(m_lo));
      return;
    end
    if (!fin) begin
      chk("timeout", 64'd0, 64'd1);
      return;
    end
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
    chk("pulse_done", 64'(done), 64'd0);
    chk("pulse_dz", 64'(divz), 64'd0);
  endtask

  logic [5:0] fsel [6] = '{F_MULT, F_MULTU, F_DIV,
                           F_DIVU, F_MTHI, F_MTLO};

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(F_MULTU, '1, '1, 0, 0);
    run_op(F_MULT, '1, '1, 0, 0);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(F_DIVU, 32'd7, 32'd2, 0, 0);
    run_op(F_DIVU, 32'h1234, 32'd0, 0, 0);
    run_op(F_DIV, 32'h8000_0000, '1, 0, 0);
    run_op(F_MULT, 32'd1234567, 32'hFFFF_0001, 3, 0);
    run_op(F_MULT, 32'd99, 32'd77, 0, 10);
    run_op(F_MTHI, 32'hDEAD_BEEF, '0, 0, 0);
    run_op(F_MTLO, 32'hCAFE_F00D, '0, 0, 0);

    // funct outside the op set must be ignored
    @(negedge clk);
    start = 1'b1; funct = F_MFHI; a_in = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_done", 64'(done), 64'd0);
    chk("ign_hi", 64'(hi), 64'(m_hi));

    // flush in IDLE beats a same-cycle start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = F_MULT;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idlefl_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      logic [W-1:0] a, b;
      f = fsel[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if (f == F_DIV && $urandom_range(0, 7) == 0) begin
        a = 32'h8000_0000; b = '1;
      end
      run_op(f, a, b, 0, 0);
    end

    // async reset mid-run, asserted away from the clock edge
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; a_in = 32'd11; b_in = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op(F_MULTU, 32'd6, 32'd7, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.
- Executes the funct-decoded MULT, MULTU, DIV, DIVU, MTHI and MTLO operations.
- Exposes HI/LO continuously so MFHI/MFLO are plain reads by the ALU result mux.
- Sits beside the ALU in EX; Busy_out feeds the hazard unit to stall any later HI/LO access.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk_in  input  1  rising-edge clock.
- Rst_in  input  1  asynchronous active-high reset.
- Start_in  input  1  request; sampled only in IDLE.
- Funct_in  input  6  R-type funct: 0x18 MULT, 0x19 MULTU, 0x1a DIV, 0x1b DIVU, 0x11 MTHI, 0x13 MTLO.
- Flush_in  input  1  synchronous abort from pipeline flush.
- A_in  input  WIDTH  rs operand / dividend / MTHI-MTLO source.
- B_in  input  WIDTH  rt operand / divisor.
- Busy_out  output  1  operation in progress.
- Done_out  output  1  one-cycle pulse: HI/LO updated.
- DivZero_out  output  1  one-cycle pulse, coincident with Done_out, for a divide with B_in=0.
- Hi_out  output  WIDTH  HI register.
- Lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; HI, LO, counter and working registers = 0; Busy_out=0, Done_out=0, DivZero_out=0.
- States: IDLE, RUN, FIX.
- IDLE + Start_in + mult/div funct: latch magnitudes of A/B (two's-complement absolute value for signed ops, raw for unsigned); latch sign flags; counter=0; go to RUN.
- IDLE + Start_in + MTHI/MTLO: write A_in to HI/LO at that edge; Done_out=1 the next cycle; stay IDLE; Busy_out stays 0.
- Start_in with any other funct (including MFHI 0x10, MFLO 0x12): ignored; no Done_out.
- RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, producing one quotient bit per cycle.
- FIX (1 cycle): apply sign correction and write HI/LO; return to IDLE.
  - Signed product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Multiply: HI = product upper half, LO = product lower half.
  - Divide: LO = quotient, HI = remainder.
- Timing: Start accepted at edge E0. Busy_out=1 from E0 until edge E0+WIDTH+1. At that edge HI/LO are written, Busy_out falls and Done_out rises for exactly one cycle. Latency = WIDTH+1 cycles.
- Start_in while Busy_out=1: ignored; no queueing.
- Divide by zero (B_in=0, signed or unsigned): HI=A_in, LO=all ones; DivZero_out pulses with Done_out; latency unchanged.
- Signed overflow (-2^(WIDTH-1) / -1): LO=-2^(WIDTH-1) (wraps), HI=0; no flag.
- Flush_in=1:
  - In RUN or FIX: next state IDLE; HI/LO unchanged; no Done_out.
  - In IDLE: suppresses a same-cycle Start_in (Flush wins).
- Hi_out/Lo_out always show the committed registers; intermediate values are never visible.
- Operand inputs are don't-care after the accept edge.
- All arithmetic is modulo 2^WIDTH per half; no X propagation from unused funct codes.

Test Plan:
- WIDTH=32, MULT A=0xFFFFFFFD (-3), B=7 -> Done_out exactly 33 cycles after accept edge; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy_out high those 33 cycles.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands (-1 × -1) -> HI=0, LO=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- Boundary divides:
  - DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF, DivZero_out one-cycle pulse with Done_out.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DivZero_out=0.
- Control:
  - Start MULT; second Start (DIVU) on cycle 3 -> ignored; result matches the first op only.
  - New MULT with Flush_in on cycle 10 -> Busy_out low next edge; HI/LO keep prior values; no Done_out.
  - MTHI A=0xDEADBEEF in IDLE -> Hi_out=0xDEADBEEF and Done_out=1 one cycle later, Busy_out never high.
- Async reset: assert Rst_in mid-RUN (cycle 5), off-edge -> Busy_out, Hi_out, Lo_out go to 0 before the next clock edge. After release, a fresh MULTU 6×7 -> LO=42, HI=0.
